// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared state encoding and Wishbone width constants for the
//               two-master round-robin Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Counter width for a given limit; a disabled timeout still needs one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_timeout
// Description : Saturating stall counter; flags expiry when the count reaches
//               TIMEOUT_CYCLES and then restarts from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_enabled
            localparam int              CW      = cnt_width(TIMEOUT_CYCLES);
            localparam logic [CW-1:0]   C_LIMIT = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] r_count;

            assign expired = (r_count == C_LIMIT);

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_count <= '0;
                end else if (clear || expired) begin
                    r_count <= '0;
                end else if (run && (r_count != C_LIMIT)) begin
                    r_count <= r_count + CW'(1);
                end
            end
        end else begin : g_disabled
            logic w_unused;
            assign w_unused = ^{clk_i, rst_n_i, run, clear};
            assign expired  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Two-master Wishbone arbiter with round-robin tie-break, no
//               preemption and a per-transfer stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AW             = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,

    input  logic [AW-1:0]    m0_adr_i,
    input  logic [WB_DW-1:0] m0_dat_i,
    input  logic [WB_SW-1:0] m0_sel_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic [WB_DW-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic [AW-1:0]    m1_adr_i,
    input  logic [WB_DW-1:0] m1_dat_i,
    input  logic [WB_SW-1:0] m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic [WB_DW-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic [AW-1:0]    s_adr_o,
    output logic [WB_DW-1:0] s_dat_o,
    output logic [WB_SW-1:0] s_sel_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [WB_DW-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,

    output logic [1:0]       grant_o
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_rr_ptr;       // 1 means m1 wins the next tie
    logic       w_stb_raw;
    logic       w_expired;
    logic       w_timeout_err;
    logic       w_own0;
    logic       w_own1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_next = r_rr_ptr ? ST_OWN1 : ST_OWN0;
                end else if (m0_cyc_i) begin
                    w_state_next = ST_OWN0;
                end else if (m1_cyc_i) begin
                    w_state_next = ST_OWN1;
                end
            end
            ST_OWN0: if (!m0_cyc_i) w_state_next = ST_IDLE;
            ST_OWN1: if (!m1_cyc_i) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_state_next == ST_OWN0) r_rr_ptr <= 1'b1;
            if (r_state == ST_IDLE && w_state_next == ST_OWN1) r_rr_ptr <= 1'b0;
        end
    end

    assign w_own0 = (r_state == ST_OWN0);
    assign w_own1 = (r_state == ST_OWN1);

    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        w_stb_raw = 1'b0;
        if (w_own0) begin
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
            s_sel_o   = m0_sel_i;
            s_we_o    = m0_we_i;
            s_cyc_o   = m0_cyc_i;
            w_stb_raw = m0_stb_i;
        end else if (w_own1) begin
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
            s_sel_o   = m1_sel_i;
            s_we_o    = m1_we_i;
            s_cyc_o   = m1_cyc_i;
            w_stb_raw = m1_stb_i;
        end
    end

    // The strobe is withdrawn on the expiry cycle so the slave sees the abort.
    assign s_stb_o       = w_stb_raw & ~w_expired;
    assign w_timeout_err = w_expired & ~s_ack_i;

    // Responses are suppressed while reset is held so an abandoned transfer
    // never completes.
    assign m0_ack_o = rst_n_i & w_own0 & s_ack_i;
    assign m1_ack_o = rst_n_i & w_own1 & s_ack_i;
    assign m0_err_o = rst_n_i & w_own0 & (s_err_i | w_timeout_err);
    assign m1_err_o = rst_n_i & w_own1 & (s_err_i | w_timeout_err);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = {w_own1, w_own0};

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .run     (s_stb_o & ~s_ack_i & ~s_err_i),
        .clear   (s_ack_i | s_err_i | (w_state_next != r_state)),
        .expired (w_expired)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_rr_arbiter
// Description : Directed and random stimulus for wb_rr_arbiter, checked
//               cycle by cycle against an ownership/stall reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

    localparam int T  = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] adr [2];
    logic [31:0]   dat [2];
    logic [3:0]    sel [2];
    logic          we  [2];
    logic          cyc [2];
    logic          stb [2];
    logic [31:0]   m_dat_o [2];
    logic          m_ack [2];
    logic          m_err [2];

    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [31:0]   s_dat_i;
    logic          s_ack_i, s_err_i;
    logic [1:0]    grant_o;

    wb_rr_arbiter #(.TIMEOUT_CYCLES(T), .AW(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_dat_o(m_dat_o[0]),
        .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_dat_o(m_dat_o[1]),
        .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
    );

    // Reference model: who owns the bus, who wins the next tie, stalls so far.
    int owner  = -1;
    int prefer = 0;
    int stall  = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [31:0] d);
        cyc[k] = c; stb[k] = s; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = 4'hF;
    endtask

    task automatic set_s(input logic a, input logic e, input logic [31:0] d);
        s_ack_i = a; s_err_i = e; s_dat_i = d;
    endtask

    // Check outputs mid-cycle, then advance the model across the next edge.
    task automatic cycle();
        logic [1:0]  e_grant;
        logic        e_cyc, e_stb, fire;
        logic [63:0] e_req, e_wdat;
        logic [3:0]  e_resp;
        int          n_owner, n_prefer, n_stall;
        @(negedge clk);
        e_grant = 2'b00; e_cyc = 1'b0; e_stb = 1'b0; e_req = '0; e_wdat = '0; e_resp = '0;
        fire = (owner >= 0) && (T != 0) && (stall == T);
        if (owner >= 0) begin
            e_grant = (owner == 0) ? 2'b01 : 2'b10;
            e_cyc   = cyc[owner];
            e_stb   = stb[owner] && !fire;
            e_req   = {27'd0, we[owner], sel[owner], adr[owner]};
            e_wdat  = {32'd0, dat[owner]};
            if (rst_n) begin
                if (owner == 0) e_resp = {s_ack_i, s_err_i || (fire && !s_ack_i), 2'b00};
                else            e_resp = {2'b00, s_ack_i, s_err_i || (fire && !s_ack_i)};
            end
        end
        chk("grant",  {62'd0, grant_o}, {62'd0, e_grant});
        chk("s_cyc",  {63'd0, s_cyc_o}, {63'd0, e_cyc});
        chk("s_stb",  {63'd0, s_stb_o}, {63'd0, e_stb});
        chk("s_req",  {27'd0, s_we_o, s_sel_o, s_adr_o}, e_req);
        chk("s_wdat", {32'd0, s_dat_o}, e_wdat);
        chk("m_resp", {60'd0, m_ack[0], m_err[0], m_ack[1], m_err[1]}, {60'd0, e_resp});
        chk("m0_dat", {32'd0, m_dat_o[0]}, {32'd0, s_dat_i});
        chk("m1_dat", {32'd0, m_dat_o[1]}, {32'd0, s_dat_i});

        n_owner = owner; n_prefer = prefer; n_stall = stall;
        if (!rst_n) begin
            n_owner = -1; n_prefer = 0; n_stall = 0;
        end else if (owner < 0) begin
            n_stall = 0;
            if (cyc[0] && cyc[1]) n_owner = prefer;
            else if (cyc[0])      n_owner = 0;
            else if (cyc[1])      n_owner = 1;
            if (n_owner >= 0) n_prefer = 1 - n_owner;
        end else if (!cyc[owner]) begin
            n_owner = -1; n_stall = 0;
        end else if (s_ack_i || s_err_i || fire) begin
            n_stall = 0;
        end else if (e_stb) begin
            n_stall = (stall < T) ? stall + 1 : T;
        end
        @(posedge clk);
        #1;
        owner = n_owner; prefer = n_prefer; stall = n_stall;
    endtask

    initial begin
        rst_n = 1'b0;
        set_m(0, 0, 0, 0, '0, '0);
        set_m(1, 0, 0, 0, '0, '0);
        set_s(0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        cycle();                                  // reset state
        rst_n = 1'b1;
        set_m(1, 0, 0, 1, 32'hAAAA_0000, 32'h5555_5555); // idle address not forwarded
        cycle();

        // m0 reads 0x100 alone; slave answers after two stalls
        set_m(0, 1, 1, 0, 32'h100, 32'h0);
        cycle();
        repeat (2) cycle();
        set_s(1, 0, 32'hDEAD_BEEF);
        cycle();
        set_s(0, 0, '0);
        set_m(0, 0, 0, 0, 32'h100, 32'h0);
        repeat (2) cycle();

        // simultaneous requests after reset: m0 first, then m1
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        set_m(0, 1, 1, 1, 32'h200, 32'h1111_0000);
        set_m(1, 1, 1, 0, 32'h300, 32'h2222_0000);
        set_s(1, 0, 32'h0BAD_F00D);
        repeat (2) cycle();
        set_m(0, 0, 0, 1, 32'h200, 32'h1111_0000);
        cycle();
        set_m(0, 1, 1, 1, 32'h204, 32'h1111_0001);
        repeat (2) cycle();

        // m1 owns the bus while m0 waits without acks
        set_s(0, 0, 32'h0);
        repeat (3) cycle();
        set_s(1, 0, 32'h1234_5678);
        cycle();
        set_s(0, 0, 32'h0);
        set_m(1, 0, 0, 0, 32'h300, 32'h0);
        repeat (3) cycle();
        set_m(0, 0, 0, 0, '0, '0);
        repeat (2) cycle();

        // timeout with a silent slave
        set_m(0, 1, 1, 0, 32'h400, 32'h0);
        repeat (T + 4) cycle();
        set_m(0, 0, 0, 0, '0, '0);
        repeat (2) cycle();

        // ack coincides with the timeout cycle
        set_m(1, 1, 1, 0, 32'h500, 32'h0);
        repeat (T + 1) cycle();
        set_s(1, 0, 32'hCAFE_0001);
        cycle();
        set_s(0, 0, '0);
        set_m(1, 0, 0, 0, '0, '0);
        repeat (2) cycle();

        // reset during an m1 stall
        set_m(1, 1, 1, 1, 32'h600, 32'h77);
        repeat (4) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        set_m(1, 0, 0, 0, '0, '0);
        repeat (2) cycle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit quiet_slave;
            quiet_slave = ((i / 60) % 2) == 1;
            for (int k = 0; k < 2; k++) begin
                if (!cyc[k]) begin
                    if ($urandom_range(2) == 0)
                        set_m(k, 1, 1, 1'($urandom), $urandom, $urandom);
                end else if ($urandom_range(7) == 0) begin
                    set_m(k, 0, 0, 0, $urandom, $urandom);
                end else begin
                    stb[k] = ($urandom_range(5) != 0);
                    adr[k] = $urandom;
                    sel[k] = 4'($urandom);
                end
            end
            set_s(quiet_slave ? ($urandom_range(19) == 0) : ($urandom_range(3) == 0),
                  $urandom_range(31) == 0, $urandom);
            rst_n = ($urandom_range(149) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
